// File: rtl/rs_mul.sv
// Reservation station for the multiply unit: holds micro-ops until both operands
// are ready, captures operands from the CDB and issues the oldest ready entry.
module rs_mul #(
    parameter int ENTRY_NUM  = 4,
    parameter int TAG_WIDTH  = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic                  i_dp_vld,
    input  logic                  i_dp_signed1,
    input  logic                  i_dp_signed2,
    input  logic                  i_dp_sel_high,
    input  logic [DATA_WIDTH-1:0] i_dp_src1,
    input  logic [DATA_WIDTH-1:0] i_dp_src2,
    input  logic                  i_dp_src1_rdy,
    input  logic                  i_dp_src2_rdy,
    input  logic [TAG_WIDTH-1:0]  i_dp_src1_tag,
    input  logic [TAG_WIDTH-1:0]  i_dp_src2_tag,
    input  logic [TAG_WIDTH-1:0]  i_dp_rd_tag,
    output logic                  o_full,
    input  logic                  i_cdb_vld,
    input  logic [TAG_WIDTH-1:0]  i_cdb_tag,
    input  logic [DATA_WIDTH-1:0] i_cdb_data,
    input  logic                  i_ex_inaccessable,
    output logic                  o_is_vld,
    output logic                  o_signed1,
    output logic                  o_signed2,
    output logic                  o_sel_high,
    output logic [DATA_WIDTH-1:0] o_src1,
    output logic [DATA_WIDTH-1:0] o_src2,
    output logic [TAG_WIDTH-1:0]  o_is_rd_tag
);
    localparam int IDX_W = $clog2(ENTRY_NUM);

    logic [ENTRY_NUM-1:0]  valid_q, valid_d;
    logic [ENTRY_NUM-1:0]  sgn1_q, sgn1_d, sgn2_q, sgn2_d, selh_q, selh_d;
    logic [ENTRY_NUM-1:0]  rdy1_q, rdy1_d, rdy2_q, rdy2_d;
    logic [TAG_WIDTH-1:0]  tag1_q [ENTRY_NUM];
    logic [TAG_WIDTH-1:0]  tag1_d [ENTRY_NUM];
    logic [TAG_WIDTH-1:0]  tag2_q [ENTRY_NUM];
    logic [TAG_WIDTH-1:0]  tag2_d [ENTRY_NUM];
    logic [TAG_WIDTH-1:0]  rd_q   [ENTRY_NUM];
    logic [TAG_WIDTH-1:0]  rd_d   [ENTRY_NUM];
    logic [DATA_WIDTH-1:0] data1_q [ENTRY_NUM];
    logic [DATA_WIDTH-1:0] data1_d [ENTRY_NUM];
    logic [DATA_WIDTH-1:0] data2_q [ENTRY_NUM];
    logic [DATA_WIDTH-1:0] data2_d [ENTRY_NUM];
    // age_q[i][j] = 1 means entry j is older than entry i
    logic [ENTRY_NUM-1:0]  age_q [ENTRY_NUM];
    logic [ENTRY_NUM-1:0]  age_d [ENTRY_NUM];

    logic                  is_vld_q, is_vld_d;
    logic                  os1_q, os1_d, os2_q, os2_d, osh_q, osh_d;
    logic [DATA_WIDTH-1:0] osrc1_q, osrc1_d, osrc2_q, osrc2_d;
    logic [TAG_WIDTH-1:0]  ord_q, ord_d;

    logic [ENTRY_NUM-1:0]  cand, grant, alloc_oh, wake1, wake2;
    logic [IDX_W-1:0]      win_idx, alloc_idx;
    logic                  dp_acc, dp_rdy1, dp_rdy2;
    logic [DATA_WIDTH-1:0] dp_data1, dp_data2;

    assign o_full   = &valid_q;
    assign dp_acc   = i_dp_vld & ~o_full & ~i_flush;
    assign cand     = valid_q & rdy1_q & rdy2_q & {ENTRY_NUM{~i_ex_inaccessable}};
    assign alloc_oh = ~valid_q & (valid_q + ENTRY_NUM'(1));

    // A not-ready source matching the concurrent broadcast is captured at dispatch
    assign dp_rdy1  = i_dp_src1_rdy | (i_cdb_vld & (i_dp_src1_tag == i_cdb_tag));
    assign dp_rdy2  = i_dp_src2_rdy | (i_cdb_vld & (i_dp_src2_tag == i_cdb_tag));
    assign dp_data1 = i_dp_src1_rdy ? i_dp_src1 : i_cdb_data;
    assign dp_data2 = i_dp_src2_rdy ? i_dp_src2 : i_cdb_data;

    for (genvar gi = 0; gi < ENTRY_NUM; gi++) begin : g_ent
        assign wake1[gi] = valid_q[gi] & ~rdy1_q[gi] & i_cdb_vld & (tag1_q[gi] == i_cdb_tag);
        assign wake2[gi] = valid_q[gi] & ~rdy2_q[gi] & i_cdb_vld & (tag2_q[gi] == i_cdb_tag);
        assign grant[gi] = cand[gi] & ~|(cand & age_q[gi]);
    end

    always_comb begin
        win_idx   = '0;
        alloc_idx = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (grant[i])    win_idx   = IDX_W'(i);
            if (alloc_oh[i]) alloc_idx = IDX_W'(i);
        end
    end

    always_comb begin
        valid_d = valid_q;
        sgn1_d  = sgn1_q;
        sgn2_d  = sgn2_q;
        selh_d  = selh_q;
        rdy1_d  = rdy1_q;
        rdy2_d  = rdy2_q;
        tag1_d  = tag1_q;
        tag2_d  = tag2_q;
        rd_d    = rd_q;
        data1_d = data1_q;
        data2_d = data2_q;
        age_d   = age_q;
        if (i_flush) begin
            valid_d = '0;
        end else begin
            valid_d = valid_q & ~grant;
            for (int i = 0; i < ENTRY_NUM; i++) begin
                if (wake1[i]) begin
                    rdy1_d[i]  = 1'b1;
                    data1_d[i] = i_cdb_data;
                end
                if (wake2[i]) begin
                    rdy2_d[i]  = 1'b1;
                    data2_d[i] = i_cdb_data;
                end
            end
            if (dp_acc) begin
                // Stale column bits from the slot's previous occupant must go
                for (int j = 0; j < ENTRY_NUM; j++) age_d[j][alloc_idx] = 1'b0;
                age_d[alloc_idx]   = valid_q;
                valid_d[alloc_idx] = 1'b1;
                sgn1_d[alloc_idx]  = i_dp_signed1;
                sgn2_d[alloc_idx]  = i_dp_signed2;
                selh_d[alloc_idx]  = i_dp_sel_high;
                rdy1_d[alloc_idx]  = dp_rdy1;
                rdy2_d[alloc_idx]  = dp_rdy2;
                tag1_d[alloc_idx]  = i_dp_src1_tag;
                tag2_d[alloc_idx]  = i_dp_src2_tag;
                data1_d[alloc_idx] = dp_data1;
                data2_d[alloc_idx] = dp_data2;
                rd_d[alloc_idx]    = i_dp_rd_tag;
            end
        end
    end

    always_comb begin
        is_vld_d = 1'b0;
        os1_d    = os1_q;
        os2_d    = os2_q;
        osh_d    = osh_q;
        osrc1_d  = osrc1_q;
        osrc2_d  = osrc2_q;
        ord_d    = ord_q;
        if (!i_flush && (|grant)) begin
            is_vld_d = 1'b1;
            os1_d    = sgn1_q[win_idx];
            os2_d    = sgn2_q[win_idx];
            osh_d    = selh_q[win_idx];
            osrc1_d  = data1_q[win_idx];
            osrc2_d  = data2_q[win_idx];
            ord_d    = rd_q[win_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            sgn1_q   <= '0;
            sgn2_q   <= '0;
            selh_q   <= '0;
            rdy1_q   <= '0;
            rdy2_q   <= '0;
            for (int i = 0; i < ENTRY_NUM; i++) begin
                tag1_q[i]  <= '0;
                tag2_q[i]  <= '0;
                rd_q[i]    <= '0;
                data1_q[i] <= '0;
                data2_q[i] <= '0;
                age_q[i]   <= '0;
            end
            is_vld_q <= 1'b0;
            os1_q    <= 1'b0;
            os2_q    <= 1'b0;
            osh_q    <= 1'b0;
            osrc1_q  <= '0;
            osrc2_q  <= '0;
            ord_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            sgn1_q   <= sgn1_d;
            sgn2_q   <= sgn2_d;
            selh_q   <= selh_d;
            rdy1_q   <= rdy1_d;
            rdy2_q   <= rdy2_d;
            tag1_q   <= tag1_d;
            tag2_q   <= tag2_d;
            rd_q     <= rd_d;
            data1_q  <= data1_d;
            data2_q  <= data2_d;
            age_q    <= age_d;
            is_vld_q <= is_vld_d;
            os1_q    <= os1_d;
            os2_q    <= os2_d;
            osh_q    <= osh_d;
            osrc1_q  <= osrc1_d;
            osrc2_q  <= osrc2_d;
            ord_q    <= ord_d;
        end
    end

    assign o_is_vld    = is_vld_q;
    assign o_signed1   = os1_q;
    assign o_signed2   = os2_q;
    assign o_sel_high  = osh_q;
    assign o_src1      = osrc1_q;
    assign o_src2      = osrc2_q;
    assign o_is_rd_tag = ord_q;

endmodule

// File: doc/rs_mul.md
# rs_mul

Reservation station for the multiply execution unit. It holds dispatched MUL/MULH/MULHSU/MULHU micro-ops until both source operands are available. Missing operands are captured from the common data bus (CDB). Each cycle it issues the oldest ready entry to the multiply unit through a registered issue port. It sits between the dispatch stage and the multiply execution unit, directly driving that unit's issue-valid, sign, high-select and operand inputs.

## Interface
Parameters:
- ENTRY_NUM, 4: number of entries (power of two, ≥2).
- TAG_WIDTH, 6: ROB/physical tag width.
- DATA_WIDTH, 32: operand width (RV32 data width).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_flush  in  1  kill all entries and any pending issue.
- i_dp_vld  in  1  dispatch one micro-op this cycle.
- i_dp_signed1 / i_dp_signed2 / i_dp_sel_high  in  1 each  multiply control bits.
- i_dp_src1 / i_dp_src2  in  DATA_WIDTH  operand value, meaningful when the matching rdy bit is 1.
- i_dp_src1_rdy / i_dp_src2_rdy  in  1  operand already available.
- i_dp_src1_tag / i_dp_src2_tag  in  TAG_WIDTH  producer tag when not ready.
- i_dp_rd_tag  in  TAG_WIDTH  destination tag.
- o_full  out  1  no free entry; dispatch must not assert i_dp_vld.
- i_cdb_vld  in  1  CDB broadcast valid.
- i_cdb_tag  in  TAG_WIDTH  broadcast tag.
- i_cdb_data  in  DATA_WIDTH  broadcast value.
- i_ex_inaccessable  in  1  execution unit cannot accept an issue this cycle.
- o_is_vld  out  1  issue valid to the multiply unit.
- o_signed1 / o_signed2 / o_sel_high  out  1 each  issued control bits.
- o_src1 / o_src2  out  DATA_WIDTH  issued operands.
- o_is_rd_tag  out  TAG_WIDTH  issued destination tag, used downstream to tag the result.

## Operation
- Per-entry state:
  - valid
  - ctrl bits
  - rd_tag
  - for each source: rdy, tag, data
  - age-matrix row (ENTRY_NUM bits)
- **Dispatch**
  - Writes the lowest-index free entry.
  - The new entry's age row marks it younger than all currently valid entries.
  - If i_dp_vld is asserted while o_full=1, the micro-op is dropped and no state changes.
- **Wakeup**
  - For every valid entry, each non-ready source whose tag equals i_cdb_tag while i_cdb_vld=1 captures i_cdb_data and sets rdy.
  - Same-cycle dispatch bypass: a dispatched source with rdy=0 whose tag matches the concurrent CDB broadcast is stored as ready with i_cdb_data.
- **Select**
  - Candidates are entries with valid=1 and both rdy bits set in the current registered state.
  - The winner is the oldest candidate per the age matrix.
  - No selection occurs when i_ex_inaccessable=1.
- **Issue**
  - The winner's fields are registered into the o_* issue outputs, and the entry's valid is cleared at the same edge.
  - When no winner exists, o_is_vld is 0 next cycle and the other o_* outputs hold their previous values.
- **o_full**: combinational AND of all valid bits from current state. An issue in the same cycle does not deassert it.
- **Flush**
  - Clears all valid bits and o_is_vld at the next edge.
  - Overrides dispatch, wakeup and issue in that cycle.
- **Reset** (async, rst_n=0):
  - All valid and rdy bits = 0; age matrix = 0.
  - o_is_vld = 0, o_signed1 = o_signed2 = o_sel_high = 0, o_src1 = o_src2 = 0, o_is_rd_tag = 0.
  - o_full = 0.
  - Reset asserted mid-operation discards all entries immediately.

## Timing
- Dispatch with both operands ready at edge N makes the entry valid after N. It is selected in cycle N+1, and o_is_vld=1 in cycle N+2. Minimum dispatch-to-issue latency is 2 cycles.
- A CDB wakeup in cycle N makes the entry selectable in cycle N+1. There is no same-cycle wakeup-to-select path.
- At most one dispatch, one CDB capture per source and one issue per cycle.
- Issue throughput: one per cycle while ready entries exist and i_ex_inaccessable=0.
- o_is_vld is a single-cycle pulse per issued micro-op. Back-to-back issues keep it high.
- The multiply unit returns its result one cycle after o_is_vld. The CDB is fed elsewhere; this block only consumes it.

## Test plan
- **Reset and readiness:** hold rst_n=0 mid-stream with 2 valid entries, then release. Required: o_is_vld=0 and o_full=0, and 4 fresh dispatches are accepted before o_full=1.
- **Ready dispatch:** dispatch src1=0x0000_0007, src2=0xFFFF_FFFD, signed1=signed2=1, rd_tag=5, both ready, at edge N. Required: o_is_vld=1 at N+2 with o_src1=7, o_src2=0xFFFF_FFFD, o_is_rd_tag=5.
- **Wakeup:** dispatch with src2 not ready, tag=12. Then broadcast cdb tag=12, data=0x1234 at cycle M. Required: issue at M+2 with o_src2=0x1234. A broadcast with tag 13 must not wake the entry.
- **Dispatch bypass:** dispatch a source with tag=9 not ready in the same cycle as a CDB broadcast tag=9, data=0xAB. Required: the entry issues 2 cycles later with data 0xAB.
- **Age order and backpressure:** make entries A (older) and B ready simultaneously while i_ex_inaccessable=1 for 3 cycles. Required: no issue during the stall. A issues first, then B in the next consecutive cycle.
- **Flush and full:** fill all 4 entries, assert i_dp_vld while o_full=1 (the micro-op must be dropped), then assert i_flush together with a dispatch. Required: next cycle all entries are empty, o_is_vld=0 and o_full=0.
